// File: rtl/mul_stage_for_607.sv
`default_nettype none
// ============================================================================
// Module   : mul_stage_for_607
// Brief    : Iterative LSB-first shift-add multiplier with valid/ready
//            handshake and operand range flag, feeding the mod-607 reducer.
// Revision : 1.0 - initial release
// ============================================================================
module mul_stage_for_607 #(
   parameter int WIDTH      = 10,
   parameter int PROD_WIDTH = 19,
   parameter int Q          = 607
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PROD_WIDTH-1:0] out_prod,
   output logic                  range_err,
   output logic                  busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH:0] c_q    = (WIDTH+1)'(Q);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q,  state_d;
   logic [2*WIDTH-1:0]      acc_q,    acc_d;
   logic [2*WIDTH-1:0]      mcand_q,  mcand_d;
   logic [WIDTH-1:0]        mplier_q, mplier_d;
   logic [CNT_W-1:0]        cnt_q,    cnt_d;
   logic [PROD_WIDTH-1:0]   prod_q,   prod_d;
   logic                    err_q,    err_d;

   logic [2*WIDTH-1:0]      w_sum;
   logic                    w_a_oor;
   logic                    w_b_oor;

   assign w_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign w_a_oor = ({1'b0, in_a} >= c_q);
   assign w_b_oor = ({1'b0, in_b} >= c_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, in_a};
               mplier_d = in_b;
               acc_d    = '0;
               cnt_d    = '0;
               err_d    = w_a_oor || w_b_oor;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            acc_d    = w_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Product register only updates on the last iteration so out_prod
            // stays put outside DONE instead of tracking the partial sums.
            if (cnt_q == c_last) begin
               prod_d  = w_sum[PROD_WIDTH-1:0];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_BUSY);
   assign out_prod  = prod_q;
   assign range_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_stage_for_607.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_stage_for_607
// Brief    : Directed self-checking bench for the mod-607 multiplier stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_stage_for_607;

   localparam int WIDTH = 10;
   localparam int PW    = 19;
   localparam int Q     = 607;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_prod;
   logic          range_err;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   mul_stage_for_607 #(.WIDTH(WIDTH), .PROD_WIDTH(PW), .Q(Q)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .range_err (range_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; hold = cycles out_ready stays low after out_valid.
   task automatic run_op(input int a, input int b, input int exp_p,
                         input logic exp_e, input int hold, input string tag);
      int lat;
      int bsy;
      logic rdy_seen;
      logic [WIDTH-1:0] av;
      lat = 0;
      while (!in_ready && lat < 40) begin
         step();
         lat++;
      end
      chk({tag, ".idle"}, in_ready, 1);
      in_a      = WIDTH'(a);
      in_b      = WIDTH'(b);
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      step();
      in_valid = 1'b0;
      av   = in_a;
      in_a = ~av;
      in_b = ~av;
      lat = 0;
      bsy = 0;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 40) begin
         if (busy) bsy++;
         if (in_ready) rdy_seen = 1'b1;
         step();
         lat++;
      end
      chk({tag, ".latency"}, lat, WIDTH);
      chk({tag, ".busy_cycles"}, bsy, WIDTH);
      chk({tag, ".no_ready_busy"}, rdy_seen, 0);
      chk({tag, ".prod"}, out_prod, exp_p);
      chk({tag, ".err"}, range_err, exp_e);
      chk({tag, ".no_ready_done"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, ".hold_valid"}, out_valid, 1);
         chk({tag, ".hold_prod"}, out_prod, exp_p);
         chk({tag, ".hold_err"}, range_err, exp_e);
      end
      out_ready = 1'b1;
      step();
      chk({tag, ".valid_drop"}, out_valid, 0);
      chk({tag, ".back_idle"}, in_ready, 1);
      chk({tag, ".prod_kept"}, out_prod, exp_p);
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int prev;
      int acc_cyc;
      int a;
      int p;
      logic seen;

      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      in_a = 10'd5; in_b = 10'd6;
      step();
      step();
      chk("rst.in_ready", in_ready, 1);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.out_prod", out_prod, 0);
      chk("rst.range_err", range_err, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      step();

      run_op(606, 606, 367236, 1'b0, 0, "max");
      run_op(0,   523, 0,      1'b0, 0, "zero");
      run_op(1,   606, 606,    1'b0, 0, "one");
      run_op(512, 2,   1024,   1'b0, 0, "p512x2");
      run_op(605, 3,   1815,   1'b0, 0, "p605x3");
      run_op(606, 606, 367236, 1'b0, 5, "hold");
      run_op(607, 2,   1214,   1'b1, 0, "oor_a");
      run_op(1023, 1023, 522241, 1'b1, 0, "oor_trunc");

      // Reset in the middle of an operation.
      in_a = 10'd300; in_b = 10'd300; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst.in_ready", in_ready, 1);
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.out_prod", out_prod, 0);
      chk("midrst.busy", busy, 0);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      chk("midrst.stale_pulse", seen, 0);
      run_op(2, 3, 6, 1'b0, 0, "after_rst");

      // Streaming sweep with in_valid held high and consumer always ready.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      prev = -1;
      for (int ai = 0; ai <= 10; ai++) begin
         a = (ai == 10) ? 606 : ai * 61;
         for (int b = 0; b <= 606; b += 7) begin
            in_a = WIDTH'(a);
            in_b = WIDTH'(b);
            lat = 0;
            while (!in_ready && lat < 40) begin
               step();
               lat++;
            end
            chk("sweep.ready", in_ready, 1);
            step();
            acc_cyc = cyc;
            if (prev >= 0) chk("sweep.spacing", acc_cyc - prev, WIDTH + 2);
            prev = acc_cyc;
            lat = 0;
            while (!out_valid && lat < 40) begin
               step();
               lat++;
            end
            p = int'(out_prod);
            chk($sformatf("sweep.mod a=%0d b=%0d", a, b), p % Q, (a * b) % Q);
         end
      end
      in_valid = 1'b0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
